// File: rtl/elevator_pkg.sv
// Shared constants and encodings for the elevator call scheduler.
package elevator_pkg;
  localparam int FLOOR_W    = 2;
  localparam int NUM_FLOORS = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10
  } car_status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10
  } sched_state_e;
endpackage

// File: rtl/elevator_call_scheduler_finder.sv
// Nearest pending floor strictly above and strictly below the car.
module floor_priority_finder #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic                  above_vld,
  output logic [FLOOR_W-1:0]    above_floor,
  output logic                  below_vld,
  output logic [FLOOR_W-1:0]    below_floor
);
  // Later loop iterations win: descending scan leaves the lowest floor
  // above, ascending scan leaves the highest floor below.
  always_comb begin
    above_vld   = 1'b0;
    above_floor = '0;
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      if (pending[f] && (f > int'(current_floor))) begin
        above_vld   = 1'b1;
        above_floor = FLOOR_W'(f);
      end
    end
  end

  always_comb begin
    below_vld   = 1'b0;
    below_floor = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (pending[f] && (f < int'(current_floor))) begin
        below_vld   = 1'b1;
        below_floor = FLOOR_W'(f);
      end
    end
  end
endmodule

// File: rtl/elevator_call_scheduler.sv
// Latches floor calls, picks the next target with a SCAN policy and clears
// calls once the car is idle at the called floor.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] call_btn,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic [1:0]            elevator_status,
  output logic [FLOOR_W-1:0]    request_floor,
  output logic                  request_valid,
  output logic [NUM_FLOORS-1:0] pending_calls,
  output logic                  call_served
);
  sched_state_e          state, state_next;
  logic                  cur_ok;
  logic [NUM_FLOORS-1:0] clear_mask;
  logic                  above_vld, below_vld;
  logic [FLOOR_W-1:0]    above_floor, below_floor, req_floor_next;

  // A position report outside the served range freezes the whole block.
  assign cur_ok = {1'b0, current_floor} < (FLOOR_W + 1)'(NUM_FLOORS);

  always_comb begin
    clear_mask = '0;
    for (int f = 0; f < NUM_FLOORS; f++)
      clear_mask[f] = cur_ok && (elevator_status == ST_IDLE) &&
                      (int'(current_floor) == f);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_calls <= '0;
      call_served   <= 1'b0;
    end else if (cur_ok) begin
      // Clear beats a simultaneous press: that call is already satisfied.
      pending_calls <= (pending_calls | call_btn) & ~clear_mask;
      call_served   <= |(pending_calls & clear_mask);
    end else begin
      call_served   <= 1'b0;
    end
  end

  floor_priority_finder #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_finder (
    .pending       (pending_calls),
    .current_floor (current_floor),
    .above_vld     (above_vld),
    .above_floor   (above_floor),
    .below_vld     (below_vld),
    .below_floor   (below_floor)
  );

  // Keep direction while calls remain ahead; reverse only when none are left.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (above_vld) state_next = S_UP;
               else if (below_vld) state_next = S_DOWN;
      S_UP:    if (!above_vld) state_next = below_vld ? S_DOWN : S_IDLE;
      S_DOWN:  if (!below_vld) state_next = above_vld ? S_UP : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (state_next)
      S_UP:    req_floor_next = above_floor;
      S_DOWN:  req_floor_next = below_floor;
      default: req_floor_next = current_floor;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      request_floor <= '0;
      request_valid <= 1'b0;
    end else if (cur_ok) begin
      state         <= state_next;
      request_floor <= req_floor_next;
      request_valid <= (state_next != S_IDLE);
    end
  end
endmodule
